// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit -- fetch stage of the 4-stage pipeline.
//
// Owns the PC, issues word-aligned requests to instruction memory, buffers the
// in-order responses in a small prefetch FIFO, and presents the head word with
// its PC to decode over a valid/stall handshake. Redirect flushes the stage and
// restarts fetch at RedirectPC. Responses to requests issued before a redirect
// are counted off and dropped.
//
// Ports
//   Clock, Reset              rising-edge clock, async active-high reset
//   ImemReq/ImemAddr/ImemAck  request handshake (accept = ImemReq & ImemAck)
//   ImemRdValid/ImemRdData    in-order response stream
//   Stall                     decode holds the head entry
//   Redirect/RedirectPC       flush and restart fetch (RedirectPC[1:0] ignored)
//   Instruction/InstrValid/InstrPC  head entry (zero when not valid)
//
// Build option
//   FETCH_BYPASS_EN  when defined, a response arriving at an empty FIFO with
//                    nothing to discard is forwarded combinationally to the
//                    outputs, and is consumed directly if decode is not stalled.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              ImemReq,
  output logic [ADDR_W-1:0] ImemAddr,
  input  logic              ImemAck,
  input  logic              ImemRdValid,
  input  logic [31:0]       ImemRdData,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC,
  output logic [31:0]       Instruction,
  output logic              InstrValid,
  output logic [ADDR_W-1:0] InstrPC
);

  localparam int              CNT_W   = $clog2(DEPTH + 1);
  localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST   = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc, resp_pc;
  logic [CNT_W-1:0]  outstanding, discard, count;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [31:0]       fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];

  logic              rsp_ok, rsp_drop, rsp_keep, fifo_empty;
  logic              bypass, pop_fifo, push, accept;
  logic [CNT_W:0]    credit_used;
  logic [ADDR_W-1:0] redirect_aligned;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok     = ImemRdValid & (outstanding != '0);
  assign rsp_drop   = rsp_ok & (discard != '0);
  assign rsp_keep   = rsp_ok & (discard == '0);
  assign fifo_empty = (count == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_keep & fifo_empty & !Redirect;
`else
  assign bypass = 1'b0;
`endif

  assign pop_fifo = !fifo_empty & !Stall;
  // A bypassed word that decode takes this cycle never enters the FIFO.
  assign push     = rsp_keep & !Redirect & !(bypass & !Stall);

  // An entry leaving the FIFO at this edge frees its slot, so the request can
  // go out in the same cycle; this is what sustains one word per cycle with
  // DEPTH=2 and a 1-cycle memory. A stalled head keeps its slot.
  assign credit_used = ({1'b0, outstanding} + {1'b0, count}) - (CNT_W + 1)'(pop_fifo);
  assign ImemReq     = !Reset & !Redirect & (credit_used < DEPTH_C);
  assign ImemAddr    = pc;
  assign accept      = ImemReq & ImemAck;

  assign redirect_aligned = {RedirectPC[ADDR_W-1:2], 2'b00};

  always_comb begin
    InstrValid  = 1'b0;
    Instruction = 32'h0;
    InstrPC     = '0;
    if (bypass) begin
      InstrValid  = 1'b1;
      Instruction = ImemRdData;
      InstrPC     = resp_pc;
    end else if (!fifo_empty) begin
      InstrValid  = 1'b1;
      Instruction = fifo_data[rd_ptr];
      InstrPC     = fifo_pc[rd_ptr];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (Redirect) begin
      pc          <= redirect_aligned;
      resp_pc     <= redirect_aligned;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= outstanding - CNT_W'(rsp_ok);
      // Every request still in flight is stale. Words already marked for
      // discard are a subset of outstanding, so the new discard count is
      // simply what remains outstanding after this cycle's response.
      discard     <= outstanding - CNT_W'(rsp_ok);
    end else begin
      if (accept)   pc      <= pc + ADDR_W'(4);
      if (rsp_drop) discard <= discard - CNT_W'(1);
      if (rsp_keep) resp_pc <= resp_pc + ADDR_W'(4);
      if (push)     wr_ptr  <= ptr_inc(wr_ptr);
      if (pop_fifo) rd_ptr  <= ptr_inc(rd_ptr);
      outstanding <= outstanding + CNT_W'(accept) - CNT_W'(rsp_ok);
      count       <= count + CNT_W'(push) - CNT_W'(pop_fifo);
    end
  end

  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= ImemRdData;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

endmodule
